// File: rtl/adat_rx_pkg.sv
// Shared types and defaults for the ADAT receive-side I2S sample collector.
package adat_rx_pkg;

    localparam int unsigned SAMPLE_BITS_DEFAULT = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/i2s_sample_collector_if.sv
// Collected-sample stream: FWFT head word with valid/ready handshake.
interface i2s_sample_collector_if #(
    parameter int unsigned SAMPLE_BITS = adat_rx_pkg::SAMPLE_BITS_DEFAULT
);
    logic [SAMPLE_BITS-1:0] sample_o;
    logic                   sample_right_o;
    logic                   sample_valid_o;
    logic                   sample_ready_i;

    modport master (
        output sample_o,
        output sample_right_o,
        output sample_valid_o,
        input  sample_ready_i
    );

    modport slave (
        input  sample_o,
        input  sample_right_o,
        input  sample_valid_o,
        output sample_ready_i
    );
endinterface

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO without a
// same-cycle read is dropped and reported on drop_c.
module sample_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             empty_c, full_c, pop_c, push_c;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c   = rd_ready_i && !empty_c;
    assign push_c  = wr_en_i && (!full_c || pop_c);
    assign drop_c  = wr_en_i && full_c && !pop_c;

    assign rd_valid_o = !empty_c;
    assign rd_data_o  = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/i2s_sample_collector.sv
// Deserialises an MSB-justified I2S stream into left/right words, aligned to
// lrclk changes, and queues them in a small FWFT FIFO.
module i2s_sample_collector
    import adat_rx_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS  = SAMPLE_BITS_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned BCLK_TIMEOUT = 64
) (
    input  logic clk_x4_i,
    input  logic reset_ni,
    input  logic i2s_data_i,
    input  logic i2s_bclk_i,
    input  logic i2s_lrclk_i,
    input  logic i2s_running_i,
    input  logic adat_locked_i,
    input  logic overflow_clr_i,
    output logic overflow_o,
    output logic link_up_o,
    i2s_sample_collector_if.master smp
);

    localparam int unsigned CW = $clog2(SAMPLE_BITS + 1);
    localparam int unsigned TW = $clog2(BCLK_TIMEOUT + 1);
    localparam int unsigned FW = SAMPLE_BITS + 1;

    logic                   bclk_q, bclk_prev_q, lrclk_q, data_q;
    state_e                 state_q, state_d;
    logic                   lr_prev_q, lr_prev_d;
    logic                   lr_prev_vld_q, lr_prev_vld_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic                   slot_right_q, slot_right_d;
    logic                   done_q, done_d;
    logic                   push_q, push_d;
    logic [FW-1:0]          push_data_q, push_data_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   link_up_q, link_up_d;
    logic                   overflow_q, overflow_d;

    logic                   rise_c, qual_ok_c, lr_edge_c, timeout_c, slot_full_c;
    logic [SAMPLE_BITS-1:0] shift_in_c;
    logic                   fifo_valid, fifo_drop;
    logic [FW-1:0]          fifo_data;

    assign rise_c      = bclk_q && !bclk_prev_q;
    assign qual_ok_c   = i2s_running_i && adat_locked_i;
    assign lr_edge_c   = rise_c && lr_prev_vld_q && (lrclk_q != lr_prev_q);
    assign timeout_c   = !rise_c && (to_cnt_q >= TW'(BCLK_TIMEOUT - 1));
    assign slot_full_c = (cnt_q == CW'(SAMPLE_BITS));
    assign shift_in_c  = {shift_q[SAMPLE_BITS-2:0], data_q};

    always_comb begin
        state_d       = state_q;
        lr_prev_d     = lr_prev_q;
        lr_prev_vld_d = lr_prev_vld_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        slot_right_d  = slot_right_q;
        done_d        = 1'b0;
        to_cnt_d      = to_cnt_q;

        if (rise_c) begin
            lr_prev_d     = lrclk_q;
            lr_prev_vld_d = 1'b1;
            to_cnt_d      = '0;
        end else if (to_cnt_q != TW'(BCLK_TIMEOUT)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                lr_prev_vld_d = 1'b0;
                to_cnt_d      = '0;
                cnt_d         = '0;
                if (qual_ok_c) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (lr_edge_c) begin
                    state_d      = ST_ACTIVE;
                    cnt_d        = CW'(1);
                    shift_d      = shift_in_c;
                    slot_right_d = lrclk_q;
                end
            end
            ST_ACTIVE: begin
                // An lrclk change always starts a new slot with its MSB.
                if (lr_edge_c) begin
                    cnt_d        = CW'(1);
                    shift_d      = shift_in_c;
                    slot_right_d = lrclk_q;
                end else if (rise_c && !slot_full_c) begin
                    cnt_d   = cnt_q + CW'(1);
                    shift_d = shift_in_c;
                    done_d  = ((cnt_q + CW'(1)) == CW'(SAMPLE_BITS));
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Losing the link drops any partial slot; queued words stay put.
        if (state_q != ST_IDLE && (!qual_ok_c || timeout_c)) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            lr_prev_vld_d = 1'b0;
            done_d        = 1'b0;
        end
    end

    always_comb begin
        push_d      = done_q;
        push_data_d = done_q ? {slot_right_q, shift_q} : push_data_q;
        link_up_d   = (state_d == ST_ACTIVE);
        overflow_d  = overflow_q;
        if (overflow_clr_i) overflow_d = 1'b0;
        if (fifo_drop)      overflow_d = 1'b1;
    end

    always_ff @(posedge clk_x4_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bclk_q        <= 1'b0;
            bclk_prev_q   <= 1'b0;
            lrclk_q       <= 1'b0;
            data_q        <= 1'b0;
            state_q       <= ST_IDLE;
            lr_prev_q     <= 1'b0;
            lr_prev_vld_q <= 1'b0;
            cnt_q         <= '0;
            shift_q       <= '0;
            slot_right_q  <= 1'b0;
            done_q        <= 1'b0;
            push_q        <= 1'b0;
            push_data_q   <= '0;
            to_cnt_q      <= '0;
            link_up_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            bclk_q        <= i2s_bclk_i;
            bclk_prev_q   <= bclk_q;
            lrclk_q       <= i2s_lrclk_i;
            data_q        <= i2s_data_i;
            state_q       <= state_d;
            lr_prev_q     <= lr_prev_d;
            lr_prev_vld_q <= lr_prev_vld_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            slot_right_q  <= slot_right_d;
            done_q        <= done_d;
            push_q        <= push_d;
            push_data_q   <= push_data_d;
            to_cnt_q      <= to_cnt_d;
            link_up_q     <= link_up_d;
            overflow_q    <= overflow_d;
        end
    end

    sample_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_x4_i),
        .rst_n      (reset_ni),
        .wr_en_i    (push_q),
        .wr_data_i  (push_data_q),
        .rd_ready_i (smp.sample_ready_i),
        .rd_valid_o (fifo_valid),
        .rd_data_o  (fifo_data),
        .drop_c     (fifo_drop)
    );

    assign smp.sample_o       = fifo_data[SAMPLE_BITS-1:0];
    assign smp.sample_right_o = fifo_data[SAMPLE_BITS];
    assign smp.sample_valid_o = fifo_valid;
    assign overflow_o         = overflow_q;
    assign link_up_o          = link_up_q;

endmodule

// File: tb/tb_i2s_sample_collector.sv
// Scoreboard bench for i2s_sample_collector: bit-banged I2S in, FIFO words out.
module tb_i2s_sample_collector;

    localparam int unsigned SB = 24;
    localparam int          SLOT = 26;

    logic clk, reset_n;
    logic data, bclk, lrclk, running, locked, ovf_clr;
    logic overflow, link_up;

    i2s_sample_collector_if #(.SAMPLE_BITS(SB)) bus ();

    i2s_sample_collector #(
        .SAMPLE_BITS  (SB),
        .FIFO_DEPTH   (4),
        .BCLK_TIMEOUT (64)
    ) dut (
        .clk_x4_i       (clk),
        .reset_ni       (reset_n),
        .i2s_data_i     (data),
        .i2s_bclk_i     (bclk),
        .i2s_lrclk_i    (lrclk),
        .i2s_running_i  (running),
        .adat_locked_i  (locked),
        .overflow_clr_i (ovf_clr),
        .overflow_o     (overflow),
        .link_up_o      (link_up),
        .smp            (bus)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [SB:0] sb_q[$];
    logic [SB:0] exp_e;
    int          lat;

    logic [SB-1:0] words [6] = '{24'h123456, 24'h89ABCD, 24'hFFFFFF,
                                 24'h000001, 24'h800000, 24'h3C3C3C};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // One serial bit: bclk low for two clocks, then high for two clocks.
    task automatic drive_bit(input logic lr, input logic d);
        @(negedge clk);
        bclk  = 1'b0;
        lrclk = lr;
        data  = d;
        @(negedge clk);
        @(negedge clk);
        bclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_slot(input logic lr, input logic [SB-1:0] w, input int nbits);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = 1'b0;
            if (i < int'(SB)) b = w[SB-1-i];
            drive_bit(lr, b);
        end
    endtask

    task automatic send_word(input logic lr, input logic [SB-1:0] w, input bit expect_it);
        if (expect_it) sb_q.push_back({lr, w});
        send_slot(lr, w, SLOT);
    endtask

    // All bits but the LSB, then raise bclk for the LSB and return at that moment.
    task automatic send_head(input logic lr, input logic [SB-1:0] w);
        sb_q.push_back({lr, w});
        send_slot(lr, w, int'(SB) - 1);
        @(negedge clk);
        bclk  = 1'b0;
        lrclk = lr;
        data  = w[0];
        @(negedge clk);
        @(negedge clk);
        bclk = 1'b1;
    endtask

    task automatic lead_in();
        send_slot(1'b1, '0, 8);
    endtask

    task automatic drain();
        int t;
        bus.sample_ready_i = 1'b1;
        t = 0;
        while (sb_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain_all_words", 32'(sb_q.size()), 0);
        repeat (4) @(negedge clk);
        #1;
        chk("drain_fifo_empty", 32'(bus.sample_valid_o), 0);
    endtask

    // Output monitor: a transfer happens at the next rising edge when valid && ready.
    always begin
        @(negedge clk);
        #1;
        if (reset_n && bus.sample_valid_o && bus.sample_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("spurious_word", 32'(bus.sample_o), 32'hFFFF_FFFF);
            end else begin
                exp_e = sb_q.pop_front();
                chk("word_data", 32'(bus.sample_o), 32'(exp_e[SB-1:0]));
                chk("word_slot", 32'(bus.sample_right_o), 32'(exp_e[SB]));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        data = 1'b0; bclk = 1'b0; lrclk = 1'b0;
        running = 1'b0; locked = 1'b0; ovf_clr = 1'b0;
        bus.sample_ready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus.sample_valid_o), 0);
        chk("rst_sample", 32'(bus.sample_o), 0);
        chk("rst_right", 32'(bus.sample_right_o), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_link_up", 32'(link_up), 0);
        @(negedge clk);
        reset_n = 1'b1;
        running = 1'b1;
        locked  = 1'b1;

        // Basic stream, latency and slot order
        bus.sample_ready_i = 1'b1;
        lead_in();
        chk("sync_link_down", 32'(link_up), 0);
        send_head(1'b0, 24'hA5A5A5);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && bus.sample_valid_o) lat = k;
        end
        chk("latency_edges", 32'(lat), 4);
        chk("link_up_active", 32'(link_up), 1);
        send_slot(1'b0, '0, 2);
        send_word(1'b1, 24'h5A5A5A, 1'b1);
        send_word(1'b0, 24'hC0FFEE, 1'b1);
        send_word(1'b1, 24'h000001, 1'b1);
        drain();

        // Overflow: six words with ready low, four retained
        bus.sample_ready_i = 1'b0;
        lead_in();
        for (int i = 0; i < 6; i++) send_word(1'(i % 2), words[i], i < 4);
        repeat (4) @(negedge clk);
        #1;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_head_valid", 32'(bus.sample_valid_o), 1);
        chk("ovf_head_data", 32'(bus.sample_o), 32'(words[0]));
        repeat (5) @(negedge clk);
        #1;
        chk("head_stable", 32'(bus.sample_o), 32'(words[0]));
        chk("ovf_sticky", 32'(overflow), 1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        #1;
        chk("ovf_cleared", 32'(overflow), 0);
        drain();

        // Full FIFO with a pop on the push cycle
        bus.sample_ready_i = 1'b0;
        lead_in();
        for (int i = 0; i < 4; i++) send_word(1'(i % 2), words[5-i], 1'b1);
        send_head(1'b0, 24'h0BEEF0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.sample_ready_i = 1'b1;
        @(negedge clk);
        bus.sample_ready_i = 1'b0;
        send_slot(1'b0, '0, 2);
        #1;
        chk("full_pop_no_ovf", 32'(overflow), 0);
        chk("full_pop_valid", 32'(bus.sample_valid_o), 1);
        drain();

        // Lock lost mid-slot, then resync
        lead_in();
        send_word(1'b0, 24'h13579B, 1'b1);
        send_slot(1'b1, 24'hFEDCBA, 10);
        @(negedge clk);
        locked = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("unlock_link_down", 32'(link_up), 0);
        @(negedge clk);
        locked = 1'b1;
        send_slot(1'b1, 24'hFEDCBA, 14);
        chk("relock_still_sync", 32'(link_up), 0);
        send_word(1'b0, 24'h2468AC, 1'b1);
        chk("relock_active", 32'(link_up), 1);
        drain();

        // bclk stall timeout, then a short slot
        lead_in();
        send_word(1'b0, 24'h0F0F0F, 1'b1);
        repeat (61) @(posedge clk);
        #1;
        chk("stall_still_up", 32'(link_up), 1);
        repeat (6) @(posedge clk);
        #1;
        chk("stall_timeout", 32'(link_up), 0);
        lead_in();
        send_word(1'b0, 24'h111111, 1'b1);
        send_slot(1'b1, 24'h222222, 20);
        send_word(1'b0, 24'h333333, 1'b1);
        drain();

        // Reset pulsed mid-slot
        bus.sample_ready_i = 1'b0;
        lead_in();
        for (int i = 0; i < 5; i++) send_word(1'(i % 2), words[i], 1'b0);
        send_slot(1'b1, 24'hABCDEF, 12);
        #1;
        chk("pre_rst_overflow", 32'(overflow), 1);
        chk("pre_rst_valid", 32'(bus.sample_valid_o), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.sample_valid_o), 0);
        chk("mid_rst_sample", 32'(bus.sample_o), 0);
        chk("mid_rst_right", 32'(bus.sample_right_o), 0);
        chk("mid_rst_overflow", 32'(overflow), 0);
        chk("mid_rst_link_up", 32'(link_up), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        send_slot(1'b1, 24'hABCDEF, 14);
        chk("post_rst_sync", 32'(link_up), 0);
        send_word(1'b0, 24'h765432, 1'b1);
        chk("post_rst_active", 32'(link_up), 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2s_sample_collector.md
I2S_SAMPLE_COLLECTOR -- requirements
Module: i2s_sample_collector

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, 24, bits captured per slot, MSB first.
REQ-002 SHALL have parameter FIFO_DEPTH, 4, output FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter BCLK_TIMEOUT, 64, clk_x4_i cycles without a bclk rising edge before the link is declared down.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk_x4_i  input  1  sole clock; all inputs are synchronous to it.
REQ-006 reset_ni  input  1  asynchronous active-low reset.
REQ-007 i2s_data_i / i2s_bclk_i / i2s_lrclk_i  input  1 each  MSB-justified serial stream from the ADAT receive channel.
REQ-008 i2s_running_i, adat_locked_i  input  1 each  upstream status qualifiers.
REQ-009 sample_o  output  SAMPLE_BITS  FIFO head word; zero when sample_valid_o is low.
REQ-010 sample_right_o  output  1  head word slot: 0 = left (lrclk low), 1 = right.
REQ-011 sample_valid_o  output  1 / sample_ready_i  input  1  first-word-fall-through handshake; transfer when both are high.
REQ-012 overflow_o  output  1  sticky drop flag / overflow_clr_i  input  1  clears the flag.
REQ-013 link_up_o  output  1  high while the state machine is in ACTIVE.

Function
REQ-014 SHALL register bclk, lrclk and data once; a bclk rising edge is registered bclk = 1 with the previous registered value = 0.
REQ-015 SHALL act only on bclk rising edges; lrclk and data are taken from the same register stage.
REQ-016 FSM SHALL have states IDLE, SYNC and ACTIVE.
REQ-017 IDLE->SYNC when i2s_running_i && adat_locked_i.
REQ-018 SYNC->ACTIVE on the first rising edge whose lrclk differs from lrclk at the previous rising edge; that edge's data bit SHALL be slot bit SAMPLE_BITS-1.
REQ-019 Any state->IDLE when either qualifier is low, or when BCLK_TIMEOUT cycles pass with no rising edge; a partial slot SHALL be discarded and the FIFO contents retained.
REQ-020 In ACTIVE, each lrclk change at a rising edge SHALL restart the bit counter, and the bit on that edge SHALL be the slot MSB.
REQ-021 After SAMPLE_BITS bits, the word and its lrclk SHALL be pushed once; further bits in the slot SHALL be ignored.
REQ-022 A slot ending before SAMPLE_BITS bits SHALL be discarded without a push or flag.
REQ-023 The bit counter SHALL saturate and never wrap within a slot.
REQ-024 Latency: sample_valid_o SHALL rise exactly 3 clk_x4_i cycles after the edge that first registers bclk high for the LSB bit, FIFO empty.
REQ-025 A push into a full FIFO with no pop in the same cycle SHALL drop the word and set overflow_o.
REQ-026 A push and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-027 overflow_o SHALL clear the cycle after overflow_clr_i; simultaneous set and clear SHALL leave it set.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra pointer bit.
REQ-029 sample_o / sample_right_o SHALL stay stable while sample_valid_o is high and sample_ready_i is low.

Reset
REQ-030 On reset_ni low, asynchronously: FSM = IDLE, FIFO empty, counters = 0, input registers = 0, all outputs = 0.
REQ-031 Reset deasserted mid-stream SHALL pass through SYNC; no word from the interrupted slot SHALL be emitted.

Structure
REQ-032 Package adat_rx_pkg SHALL hold the FSM state enum and the SAMPLE_BITS default.
REQ-033 FIFO SHALL be sub-module sample_fifo: synchronous, FWFT, parameterised by width and depth, asynchronous active-low reset.
REQ-034 Implementation target: 120-400 lines of RTL.

Verification
REQ-035 Locked stream with bclk every 4 clk cycles, left 0xA5A5A5, right 0x5A5A5A -> words popped in order, sample_right_o 0 then 1, link_up_o high from the first lrclk change.
REQ-036 sample_ready_i held low for 6 words, FIFO_DEPTH = 4 -> 4 words retained, 2 dropped, overflow_o = 1; then pulse overflow_clr_i -> overflow_o = 0 next cycle.
REQ-037 Full FIFO with sample_ready_i high on the push cycle -> no drop, overflow_o stays 0.
REQ-038 adat_locked_i dropped after 10 bits of a slot -> IDLE, no partial word; on relock, first word comes only after SYNC.
REQ-039 bclk frozen for 64 cycles -> link_up_o = 0 on cycle 65; 20-bit short slot -> discarded, no push.
REQ-040 reset_ni pulsed low mid-slot -> all outputs 0 immediately; the next complete slot after sync is emitted correctly.
